// File: rtl/d_ext_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : d_ext_pipe_pkg
//  Description : Shared definitions for the decode-stage immediate extender.
//                Holds the mode codes and the default widths.
//  Revision    : 1.0  initial release
// ============================================================================
`ifndef D_EXT_IN_W_DEFAULT
`define D_EXT_IN_W_DEFAULT 16
`endif
`ifndef D_EXT_OUT_W_DEFAULT
`define D_EXT_OUT_W_DEFAULT 32
`endif

package d_ext_pipe_pkg;

  localparam int EXT_MODE_W    = 3;
  localparam int EXT_IN_W_DEF  = `D_EXT_IN_W_DEFAULT;
  localparam int EXT_OUT_W_DEF = `D_EXT_OUT_W_DEFAULT;

  localparam logic [EXT_MODE_W-1:0] EXT_ZERO = 3'd0;
  localparam logic [EXT_MODE_W-1:0] EXT_SIGN = 3'd1;
  localparam logic [EXT_MODE_W-1:0] EXT_LUI  = 3'd2;
  localparam logic [EXT_MODE_W-1:0] EXT_BR   = 3'd3;
  localparam logic [EXT_MODE_W-1:0] EXT_ONES = 3'd4;

endpackage

`default_nettype wire

// File: rtl/d_ext_pipe_ext_core.sv
`default_nettype none
// ============================================================================
//  Module      : d_ext_pipe_ext_core
//  Description : Purely combinational immediate extension. Produces the
//                OUT_W-bit result and an error flag for unknown mode codes
//                (unknown codes fall back to zero extension).
//  Ports       : imm_i  (IN_W)   raw immediate
//                mode_i (MODE_W) extension mode
//                data_o (OUT_W)  extended value
//                err_o  (1)      mode code was illegal
//  Revision    : 1.0  initial release
// ============================================================================
module d_ext_pipe_ext_core
  import d_ext_pipe_pkg::*;
#(
  parameter int IN_W   = EXT_IN_W_DEF,
  parameter int OUT_W  = EXT_OUT_W_DEF,
  parameter int MODE_W = EXT_MODE_W
) (
  input  logic [IN_W-1:0]   imm_i,
  input  logic [MODE_W-1:0] mode_i,
  output logic [OUT_W-1:0]  data_o,
  output logic              err_o
);

  localparam int PAD_W = OUT_W - IN_W;

  logic [OUT_W-1:0] w_sext;
  assign w_sext = {{PAD_W{imm_i[IN_W-1]}}, imm_i};

  always_comb begin
    data_o = {{PAD_W{1'b0}}, imm_i};
    err_o  = 1'b0;
    case (mode_i)
      MODE_W'(EXT_ZERO): data_o = {{PAD_W{1'b0}}, imm_i};
      MODE_W'(EXT_SIGN): data_o = w_sext;
      MODE_W'(EXT_LUI):  data_o = {imm_i, {PAD_W{1'b0}}};
      // Branch offset: word offset to byte offset, top two bits fall off.
      MODE_W'(EXT_BR):   data_o = {w_sext[OUT_W-3:0], 2'b00};
      MODE_W'(EXT_ONES): data_o = {{PAD_W{1'b1}}, imm_i};
      default:           err_o  = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/d_ext_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : d_ext_pipe
//  Description : Pipelined immediate extender with a 2-entry skid buffer
//                (main register M drives the outputs, skid register S catches
//                the beat accepted while the output is stalled). in_ready is
//                registered, so there is no combinational ready path.
//  Ports       : clk_i, rst_ni (async active-low), flush_i (sync clear)
//                in_valid_i / in_ready_o / in_imm_i / in_mode_i   upstream
//                out_valid_o / out_ready_i / out_data_o / out_err_o downstream
//  Config      : EXT_BYPASS_EN - when defined, a beat accepted while EMPTY
//                with out_ready_i=1 and no flush goes straight to the output
//                in the same cycle and is not stored.
//  Revision    : 1.0  initial release
// ============================================================================
module d_ext_pipe
  import d_ext_pipe_pkg::*;
#(
  parameter int IN_W   = EXT_IN_W_DEF,
  parameter int OUT_W  = EXT_OUT_W_DEF,
  parameter int MODE_W = EXT_MODE_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [IN_W-1:0]   in_imm_i,
  input  logic [MODE_W-1:0] in_mode_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [OUT_W-1:0]  out_data_o,
  output logic              out_err_o
);

  // Occupancy: EMPTY (none), ONE (M), FULL (M and S).
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]       state_q,    state_d;
  logic             in_ready_q, in_ready_d;
  logic [OUT_W-1:0] m_data_q,   m_data_d;
  logic             m_err_q,    m_err_d;
  logic [OUT_W-1:0] s_data_q,   s_data_d;
  logic             s_err_q,    s_err_d;

  logic [OUT_W-1:0] w_core_data;
  logic             w_core_err;
  logic             w_m_valid;
  logic             w_bypass;
  logic             w_acc;
  logic             w_pop;

  d_ext_pipe_ext_core #(
    .IN_W   (IN_W),
    .OUT_W  (OUT_W),
    .MODE_W (MODE_W)
  ) u_core (
    .imm_i  (in_imm_i),
    .mode_i (in_mode_i),
    .data_o (w_core_data),
    .err_o  (w_core_err)
  );

  assign w_m_valid = (state_q != ST_EMPTY);
  assign w_acc     = in_valid_i && in_ready_q;
  // Pop of a stored entry only; a bypassed beat never enters M.
  assign w_pop     = w_m_valid && out_ready_i;

`ifdef EXT_BYPASS_EN
  assign w_bypass    = (state_q == ST_EMPTY) && out_ready_i && !flush_i && in_valid_i;
  assign out_valid_o = w_m_valid || w_bypass;
  assign out_data_o  = w_bypass ? w_core_data : m_data_q;
  assign out_err_o   = w_bypass ? w_core_err  : m_err_q;
`else
  assign w_bypass    = 1'b0;
  assign out_valid_o = w_m_valid;
  assign out_data_o  = m_data_q;
  assign out_err_o   = m_err_q;
`endif

  assign in_ready_o = in_ready_q;

  always_comb begin
    state_d  = state_q;
    m_data_d = m_data_q;
    m_err_d  = m_err_q;
    s_data_d = s_data_q;
    s_err_d  = s_err_q;
    case (state_q)
      ST_EMPTY: begin
        if (w_acc && !w_bypass) begin
          m_data_d = w_core_data;
          m_err_d  = w_core_err;
          state_d  = ST_ONE;
        end
      end
      ST_ONE: begin
        if (w_acc && w_pop) begin
          m_data_d = w_core_data;
          m_err_d  = w_core_err;
        end else if (w_acc) begin
          s_data_d = w_core_data;
          s_err_d  = w_core_err;
          state_d  = ST_FULL;
        end else if (w_pop) begin
          state_d  = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only the drain path applies.
        if (w_pop) begin
          m_data_d = s_data_q;
          m_err_d  = s_err_q;
          state_d  = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush wins over any same-cycle accept or pop; data regs may update but
    // are invisible once the occupancy is EMPTY.
    if (flush_i) begin
      state_d = ST_EMPTY;
    end
    in_ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
      m_data_q   <= '0;
      m_err_q    <= 1'b0;
      s_data_q   <= '0;
      s_err_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      m_data_q   <= m_data_d;
      m_err_q    <= m_err_d;
      s_data_q   <= s_data_d;
      s_err_q    <= s_err_d;
    end
  end

endmodule

`default_nettype wire
